// File: rtl/mult32_op_ctrl.sv
// mult32_op_ctrl: RV32M multiply sequencer for the single-cycle
// multiplier tree, with a one-entry product reuse cache.
module mult32_op_ctrl #(
  parameter int MUL_LAT  = 1,
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             dp_start,
  output logic [32:0]      dp_a,
  output logic [32:0]      dp_b,
  input  logic [63:0]      dp_product,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] CNT_INIT =
    (MUL_LAT > 0) ? 3'(MUL_LAT - 1) : 3'd0;
  localparam bit LAT0 = (MUL_LAT == 0);

  state_t           state;
  logic [2:0]       cnt;
  logic [1:0]       op_q;
  logic [31:0]      rs1_q;
  logic [31:0]      rs2_q;
  logic             sa_q;
  logic             sb_q;
  logic [TAG_W-1:0] tag_q;

  logic             c_vld;
  logic [63:0]      c_prod;
  logic [31:0]      c_rs1;
  logic [31:0]      c_rs2;
  logic             c_sa;
  logic             c_sb;

  logic sa;
  logic sb;
  logic hs;
  logic hit;
  logic smp;

  function automatic logic [31:0] pick(
    input logic [1:0]  op,
    input logic [63:0] p
  );
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (1'b1)
      (req_op == 2'b01): begin
        sa = 1'b1;
        sb = 1'b1;
      end
      (req_op == 2'b10): sa = 1'b1;
      default: ;
    endcase
  end

  assign req_ready = (state == IDLE) & ~flush;
  assign hs = req_valid & req_ready;

  // MUL's low word does not depend on signedness, so any cached pair serves it
  assign hit = CACHE_EN & c_vld
             & (req_rs1 == c_rs1)
             & (req_rs2 == c_rs2)
             & ((req_op == 2'b00) | ({sa, sb} == {c_sa, c_sb}));

  assign smp = ((state == ISSUE) & LAT0)
             | ((state == WAIT) & (cnt == 3'd0));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      op_q       <= 2'b00;
      rs1_q      <= '0;
      rs2_q      <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      tag_q      <= '0;
      c_vld      <= 1'b0;
      c_prod     <= '0;
      c_rs1      <= '0;
      c_rs2      <= '0;
      c_sa       <= 1'b0;
      c_sb       <= 1'b0;
      dp_start   <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      busy       <= 1'b0;
    end else if (flush) begin
      state      <= IDLE;
      dp_start   <= 1'b0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      c_vld      <= 1'b0;
    end else begin
      dp_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (hs) begin
            op_q  <= req_op;
            rs1_q <= req_rs1;
            rs2_q <= req_rs2;
            sa_q  <= sa;
            sb_q  <= sb;
            tag_q <= req_tag;
            busy  <= 1'b1;
            if (hit) begin
              resp_data  <= pick(req_op, c_prod);
              resp_tag   <= req_tag;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              dp_start <= 1'b1;
              dp_a     <= {sa & req_rs1[31], req_rs1};
              dp_b     <= {sb & req_rs2[31], req_rs2};
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!LAT0) begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 3'd0) cnt <= cnt - 3'd1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (smp) begin
        resp_data  <= pick(op_q, dp_product);
        resp_tag   <= tag_q;
        resp_valid <= 1'b1;
        state      <= RESP;
        c_vld      <= CACHE_EN;
        c_prod     <= dp_product;
        c_rs1      <= rs1_q;
        c_rs2      <= rs2_q;
        c_sa       <= sa_q;
        c_sb       <= sb_q;
      end
    end
  end

endmodule

// File: tb/tb_mult32_op_ctrl.sv
// tb_mult32_op_ctrl: table, random and corner-case checks of the
// multiply sequencer against an arithmetic reference model.
module tb_mult32_op_ctrl;

  localparam int LAT = 1;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_tag;
  logic        dp_start;
  logic [32:0] dp_a;
  logic [32:0] dp_b;
  logic [63:0] dp_product;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bit          m_vld;
  logic [31:0] m_rs1;
  logic [31:0] m_rs2;
  bit          m_sa;
  bit          m_sb;

  mult32_op_ctrl #(
    .MUL_LAT(LAT),
    .TAG_W(5),
    .CACHE_EN(1'b1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_rs1(req_rs1),
    .req_rs2(req_rs2),
    .req_tag(req_tag),
    .dp_start(dp_start),
    .dp_a(dp_a),
    .dp_b(dp_b),
    .dp_product(dp_product),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data(resp_data),
    .resp_tag(resp_tag),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath stand-in: the true product appears only in the sample cycle
  initial begin
    int k;
    logic [63:0] prod_q;
    logic signed [65:0] full;
    k = 100;
    prod_q = '0;
    dp_product = '0;
    forever begin
      @(negedge clk);
      if (dp_start) begin
        k = 0;
        full = $signed(dp_a) * $signed(dp_b);
        prod_q = full[63:0];
      end else if (k < 100) begin
        k++;
      end
      dp_product = (k == LAT) ? prod_q : {$urandom, $urandom};
    end
  end

  function automatic logic [31:0] ref_mul(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] p;
    bit sa;
    bit sb;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    a64 = {(sa && a[31]) ? 32'hFFFF_FFFF : 32'h0, a};
    b64 = {(sb && b[31]) ? 32'hFFFF_FFFF : 32'h0, b};
    p = a64 * b64;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic bit model_hit(
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bit sa;
    bit sb;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    return m_vld && (a == m_rs1) && (b == m_rs2)
        && ((op == 2'b00) || ((sa == m_sa) && (sb == m_sb)));
  endfunction

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_op(
    input string nm,
    input logic [1:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0] tag,
    input logic [31:0] exp_d,
    input bit exp_hit,
    input int hold
  );
    int lat;
    int starts;
    logic [32:0] got_a;
    logic [32:0] got_b;
    bit sa;
    bit sb;
    sa = (op == 2'b01) || (op == 2'b10);
    sb = (op == 2'b01);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    req_tag = tag;
    chk({nm, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    starts = 0;
    got_a = '0;
    got_b = '0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (dp_start) begin
        starts++;
        got_a = dp_a;
        got_b = dp_b;
      end
      if (resp_valid) break;
    end
    chk({nm, "_lat"}, 64'(lat), exp_hit ? 64'd1 : 64'(LAT + 2));
    chk({nm, "_starts"}, 64'(starts), exp_hit ? 64'd0 : 64'd1);
    chk({nm, "_data"}, 64'(resp_data), 64'(exp_d));
    chk({nm, "_tag"}, 64'(resp_tag), 64'(tag));
    if (!exp_hit) begin
      chk({nm, "_dpa"}, 64'(got_a), 64'({sa & a[31], a}));
      chk({nm, "_dpb"}, 64'(got_b), 64'({sb & b[31], b}));
      m_vld = 1'b1;
      m_rs1 = a;
      m_rs2 = b;
      m_sa = sa;
      m_sb = sb;
    end
    if (hold > 0) begin
      resp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({nm, "_hold"},
            64'({resp_valid, resp_data, resp_tag, req_ready}),
            64'({1'b1, exp_d, tag, 1'b0}));
      end
      resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_done"}, 64'({resp_valid, busy}), 64'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] d;
    bit          hit;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    bit          rv;
    logic [3:0]  w;

    tbl[0]  = '{2'b00, 32'h0000_0003, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFD, 1'b0};
    tbl[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0000, 1'b0};
    tbl[2]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0};
    tbl[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0};
    tbl[4]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0001, 1'b1};
    tbl[5]  = '{2'b01, 32'h8000_0000, 32'h0000_0002, 5'd5,  32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{2'b00, 32'h8000_0000, 32'h0000_0002, 5'd6,  32'h0000_0000, 1'b1};
    tbl[7]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 5'd8,  32'h0000_0001, 1'b0};
    tbl[8]  = '{2'b11, 32'h8000_0000, 32'h0000_0002, 5'd9,  32'h0000_0001, 1'b1};
    tbl[9]  = '{2'b01, 32'h8000_0000, 32'h0000_0002, 5'd10, 32'hFFFF_FFFF, 1'b0};
    tbl[10] = '{2'b00, 32'h0000_0000, 32'h0000_0000, 5'd31, 32'h0000_0000, 1'b0};

    resetn = 1'b0;
    flush = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_rs1 = '0;
    req_rs2 = '0;
    req_tag = '0;
    resp_ready = 1'b1;
    m_vld = 1'b0;
    m_rs1 = '0;
    m_rs2 = '0;
    m_sa = 1'b0;
    m_sb = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({dp_start, resp_valid, busy, req_ready}), 64'b0001);
    chk("rst_dpa", 64'(dp_a), 64'd0);
    chk("rst_dpb", 64'(dp_b), 64'd0);
    chk("rst_resp", 64'({resp_data, resp_tag}), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
            tbl[i].tag, tbl[i].d, tbl[i].hit, 0);
    end

    do_op("bp", 2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 5'd22,
          ref_mul(2'b10, 32'h1234_5678, 32'h9ABC_DEF0),
          model_hit(2'b10, 32'h1234_5678, 32'h9ABC_DEF0), 5);

    // flush while waiting on the tree; the product sample edge is discarded
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b00;
    req_rs1 = 32'h0000_1234;
    req_rs2 = 32'h0000_5678;
    req_tag = 5'd12;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("fl_issue", 64'(dp_start), 64'd1);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_idle", 64'({resp_valid, busy, dp_start}), 64'd0);
    req_valid = 1'b1;
    chk("fl_noready", 64'(req_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("fl_noaccept", 64'({busy, dp_start, resp_valid}), 64'd0);
    rv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rv = rv | resp_valid;
    end
    chk("fl_noresp", 64'(rv), 64'd0);
    m_vld = 1'b0;
    do_op("fl_reissue", 2'b00, 32'h0000_1234, 32'h0000_5678, 5'd12,
          32'h0626_0060, 1'b0, 0);

    // reset during ISSUE
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 2'b01;
    req_rs1 = 32'h0000_ABCD;
    req_rs2 = 32'h0000_0010;
    req_tag = 5'd5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rm_issue", 64'(dp_start), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rm_ctl", 64'({dp_start, resp_valid, busy}), 64'd0);
    chk("rm_dp", 64'({dp_a[31:0], dp_b[31:0]}), 64'd0);
    chk("rm_resp", 64'({resp_data, resp_tag}), 64'd0);
    resetn = 1'b1;
    m_vld = 1'b0;
    @(negedge clk);
    chk("rm_ready", 64'({req_ready, busy}), 64'b10);
    do_op("rm_reissue", 2'b01, 32'h0000_ABCD, 32'h0000_0010, 5'd5,
          32'h0000_0000, 1'b0, 0);

    // random ops, reusing operands often to exercise the cache
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < 40; i++) begin
      w = 4'($urandom_range(0, 15));
      if (w[0]) a = $urandom;
      if (w[1]) b = $urandom;
      if (w[3:2] == 2'b00) a = 32'h8000_0000;
      op = 2'($urandom_range(0, 3));
      tag = 5'($urandom_range(0, 31));
      do_op($sformatf("rnd%0d", i), op, a, b, tag,
            ref_mul(op, a, b), model_hit(op, a, b),
            $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mult32_op_ctrl.md
Name: mult32_op_ctrl

Overview:
Sequencing controller for the 32-bit single-cycle multiplier datapath (partial-product generator plus CSA3_2/CSA4_2 compressor tree and final adder).
- Accepts RV32M multiply ops (MUL/MULH/MULHSU/MULHU) from the execute stage over a valid/ready handshake.
- Sign-extends operands to 33 bits, issues them to the datapath and waits a parameterised latency.
- Selects the low or high result word and returns it with a tag.
- Keeps a one-entry product cache so a MULH*/MUL pair on identical operands completes without reissuing the tree.

Parameters:
MUL_LAT, 1, cycles from the dp_start cycle to the cycle in which dp_product is sampled; legal range 0..7 (0 = same cycle).
TAG_W, 5, width of the request/response tag (destination register index).
CACHE_EN, 1, 1 enables the product-reuse cache; 0 forces every op to issue.

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  synchronous active-low reset
flush  in  1  pipeline flush; abort current op
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req_rs1  in  32  multiplicand
req_rs2  in  32  multiplier
req_tag  in  TAG_W  tag echoed on the response
dp_start  out  1  one-cycle issue strobe to the datapath
dp_a  out  33  sign-extended rs1
dp_b  out  33  sign-extended rs2
dp_product  in  64  low 64 bits of the datapath product
resp_valid  out  1  response valid
resp_ready  in  1  consumer accepts the response
resp_data  out  32  result word
resp_tag  out  TAG_W  tag of the completed op
busy  out  1  state != IDLE

Behaviour:
- Reset (resetn=0 at a clock edge) puts the block in IDLE with all registered outputs at 0: dp_start, dp_a, dp_b, resp_valid, resp_data, resp_tag, busy. cache_valid is cleared.
- req_ready = (state==IDLE) & ~flush, combinational. After reset it reads 1 whenever flush=0.
- Signedness:
  - MUL: sa=0, sb=0 (the low word is signedness-independent).
  - MULH: sa=1, sb=1. MULHSU: sa=1, sb=0. MULHU: sa=0, sb=0.
  - dp_a = {sa&rs1[31], rs1}; dp_b = {sb&rs2[31], rs2}.
- Result selection: MUL takes dp_product[31:0]; all others take dp_product[63:32].
- Cache hit condition: CACHE_EN=1, cache_valid=1, rs1 and rs2 equal the cached operands, and either op==MUL or (sa,sb) equal the cached sign pair.
- State machine: IDLE, ISSUE, WAIT, RESP.
  - IDLE: on handshake at cycle T, latch op, operands, sa/sb and tag.
    - Hit: load resp_data from the cached 64-bit product, go to RESP. resp_valid is high at T+1.
    - Miss: go to ISSUE.
  - ISSUE: dp_start=1 for exactly this cycle (T+1); dp_a/dp_b are stable from T+1 until the product is sampled.
    - MUL_LAT=0: sample dp_product this cycle and go to RESP.
    - Otherwise: load the counter with MUL_LAT-1 and go to WAIT.
  - WAIT: decrement the counter each cycle. When it is 0, sample dp_product and go to RESP. The sample cycle is T+1+MUL_LAT.
  - Sampling dp_product writes the cache (product, rs1, rs2, sa, sb) and sets cache_valid.
  - RESP: resp_valid=1. resp_data and resp_tag are held stable until resp_valid&resp_ready, then the block returns to IDLE.
- Miss latency: resp_valid is high at T+2+MUL_LAT (T+3 for the default).
- Throughput: one op outstanding. No request is accepted in the cycle a response completes; IDLE is re-entered first.
- flush:
  - Any state goes to IDLE at the next edge; resp_valid drops and dp_start is forced to 0.
  - cache_valid is cleared, including for a product sampled in the same cycle.
  - A request presented with flush=1 is not accepted.
- Reset mid-operation behaves as flush, with all outputs taken to their reset values.
- dp_product is ignored outside the sample cycle.

Test Plan:
1. Miss path: MUL rs1=0x00000003 rs2=0xFFFFFFFF tag=7 accepted at cycle T, MUL_LAT=1 → dp_start at T+1 with dp_a=0x0_00000003 and dp_b=0x0_FFFFFFFF; resp_valid at T+3 with data=0xFFFFFFFD, tag=7.
2. Signedness: MULH/MULHSU/MULHU with rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → data 0x00000000, 0xFFFFFFFF and 0xFFFFFFFE respectively. dp_a is 0x1_FFFFFFFF for MULH and MULHSU, 0x0_FFFFFFFF for MULHU.
3. Reuse:
   - MULH then MUL on rs1=0x80000000, rs2=0x00000002 → second op responds at T+1 with data 0x00000000 and no dp_start.
   - MULHU after MULH on the same operands → miss, dp_start pulses.
4. Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid, resp_data and resp_tag stable; req_ready=0 throughout.
5. Flush: assert flush in WAIT (MUL_LAT=3) → IDLE next cycle with no resp_valid. An identical following op misses and reissues dp_start.
6. Reset mid-op: resetn=0 during ISSUE → all outputs 0 and busy=0 the next cycle; req_ready=1 after resetn=1.
